shifter_pipe: RTL and testbench

Pipelined, parametrised barrel shifter with valid/ready handshakes on both sides. It is the successor to the single-cycle 32-bit ALU shifter. It lets the datapath place shifts on a multi-cycle execute path, such as a pipelined CPU or a DMA byte-lane aligner, without lengthening the critical path. It supports logical and arithmetic shifts in both directions, optional rotates, and a sideband tag that travels with each operation.

---
 rtl/shifter_pipe_pkg.sv | 55 +++++
 rtl/shifter_pipe_stage.sv | 77 +++++++
 rtl/shifter_pipe.sv | 84 ++++++++
 tb/tb_shifter_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings, decoded op kinds, helpers.
// Rotates (ROL/ROR) and the 11x pass-through exist only when SHIFTER_ROTATE_EN is defined.
package shifter_pipe_pkg;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;

  typedef enum logic [2:0] {
    K_SLL,
    K_SRL,
    K_SRA,
    K_ROL,
    K_ROR,
    K_PASS
  } op_kind_e;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic op_kind_e decode_op(input logic [2:0] op);
    op_kind_e k;
`ifdef SHIFTER_ROTATE_EN
    case (op)
      OP_SRL:          k = K_SRL;
      OP_SRA:          k = K_SRA;
      OP_ROL:          k = K_ROL;
      OP_ROR:          k = K_ROR;
      OP_PASS, 3'b111: k = K_PASS;
      default:         k = K_SLL;
    endcase
`else
    // Without rotate support op[2] is a don't-care: 1xx behaves as 0xx.
    case (op)
      OP_SRL, OP_PASS: k = K_SRL;
      OP_SRA, 3'b111:  k = K_SRA;
      default:         k = K_SLL;
    endcase
`endif
    return k;
  endfunction

  // Right-going ops run through the left-shift datapath on a bit-reversed operand.
  function automatic logic is_right(input op_kind_e k);
    return (k == K_SRL) || (k == K_SRA) || (k == K_ROR);
  endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// One register stage of the barrel shifter: NUM_LEVELS left-shift levels starting at FIRST_LEVEL.
// Wrap fill for rotates is built only under SHIFTER_ROTATE_EN.
module shifter_pipe_stage
  import shifter_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_W     = 5,
  parameter int TAG_W       = 4,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SHAMT_W-1:0]    shamt_i,
  input  op_kind_e              kind_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [SHAMT_W-1:0]    shamt_o,
  output op_kind_e              kind_o,
  output logic [TAG_W-1:0]      tag_o
);

  logic [NUM_LEVELS:0][DATA_WIDTH-1:0] lvl;
  logic [DATA_WIDTH-1:0]               data_d;
  logic                                vld_q;
  logic [DATA_WIDTH-1:0]               data_q;
  logic [SHAMT_W-1:0]                  shamt_q;
  op_kind_e                            kind_q;
  logic [TAG_W-1:0]                    tag_q;

  assign lvl[0] = data_i;

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_level
    localparam int K = 1 << (FIRST_LEVEL + l);
    logic [K-1:0] fill;

    // On the reversed operand the original sign bit sits at bit 0 and stays there.
    always_comb begin
      fill = '0;
      if (kind_i == K_SRA) fill = {K{lvl[l][0]}};
`ifdef SHIFTER_ROTATE_EN
      if (kind_i == K_ROL || kind_i == K_ROR) fill = lvl[l][DATA_WIDTH-1 -: K];
`endif
    end

    assign lvl[l+1] = shamt_i[FIRST_LEVEL+l] ? {lvl[l][DATA_WIDTH-K-1:0], fill} : lvl[l];
  end

  assign data_d = lvl[NUM_LEVELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      kind_q  <= K_SLL;
      tag_q   <= '0;
    end else if (adv_i) begin
      vld_q   <= vld_i;
      data_q  <= data_d;
      shamt_q <= shamt_i;
      kind_q  <= kind_i;
      tag_q   <= tag_i;
    end
  end

  assign vld_o   = vld_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign kind_o  = kind_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides; STAGES register stages, lock-step stall.
// Define SHIFTER_ROTATE_EN to add ROL/ROR and the 11x pass-through.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int  DATA_WIDTH       = 32,
  parameter int  LEVELS_PER_STAGE = 2,
  parameter int  TAG_W            = 4,
  localparam int SHAMT_W          = log2_ceil(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [SHAMT_W-1:0]    in_shamt,
  input  logic [2:0]            in_op,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int STAGES = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] x);
    return {<<{x}};
  endfunction

  logic                                 adv;
  op_kind_e                             kind_in;
  logic [STAGES:0]                      vld_s;
  logic [STAGES:0][DATA_WIDTH-1:0]      data_s;
  logic [STAGES:0][SHAMT_W-1:0]         shamt_s;
  op_kind_e [STAGES:0]                  kind_s;
  logic [STAGES:0][TAG_W-1:0]           tag_s;
  logic                                 unused_shamt;

  // Whole pipe moves as one; bubbles are kept rather than squeezed out.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;

  assign kind_in    = decode_op(in_op);
  assign vld_s[0]   = in_valid & in_ready;
  assign data_s[0]  = is_right(kind_in) ? bit_rev(in_a) : in_a;
  assign shamt_s[0] = (kind_in == K_PASS) ? '0 : in_shamt;
  assign kind_s[0]  = kind_in;
  assign tag_s[0]   = in_tag;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * LEVELS_PER_STAGE;
    localparam int LAST  = ((s + 1) * LEVELS_PER_STAGE < SHAMT_W) ? (s + 1) * LEVELS_PER_STAGE
                                                                  : SHAMT_W;
    shifter_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_W    (SHAMT_W),
      .TAG_W      (TAG_W),
      .FIRST_LEVEL(FIRST),
      .NUM_LEVELS (LAST - FIRST)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (adv),
      .vld_i  (vld_s[s]),
      .data_i (data_s[s]),
      .shamt_i(shamt_s[s]),
      .kind_i (kind_s[s]),
      .tag_i  (tag_s[s]),
      .vld_o  (vld_s[s+1]),
      .data_o (data_s[s+1]),
      .shamt_o(shamt_s[s+1]),
      .kind_o (kind_s[s+1]),
      .tag_o  (tag_s[s+1])
    );
  end

  // Output side: undo the operand reversal for right-going ops (wiring only).
  assign out_valid    = vld_s[STAGES];
  assign out_result   = is_right(kind_s[STAGES]) ? bit_rev(data_s[STAGES]) : data_s[STAGES];
  assign out_tag      = tag_s[STAGES];
  assign unused_shamt = ^shamt_s[STAGES];

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe (W=32, 2 levels/stage): directed values, streaming,
// backpressure, randomized traffic against a behavioural model, and reset mid-flight.
module tb_shifter_pipe;

  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [4:0]    in_shamt = '0;
  logic [2:0]    in_op = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  shifter_pipe #(.DATA_WIDTH(DW), .LEVELS_PER_STAGE(2), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [4:0] sh,
                                          input logic [2:0] op);
    int s;
    s = int'(sh);
`ifdef SHIFTER_ROTATE_EN
    case (op)
      3'd0, 3'd1: return a << s;
      3'd2:       return a >> s;
      3'd3:       return $unsigned($signed(a) >>> s);
      3'd4:       return (s == 0) ? a : ((a << s) | (a >> (DW - s)));
      3'd5:       return (s == 0) ? a : ((a >> s) | (a << (DW - s)));
      default:    return a;
    endcase
`else
    case (op[1:0])
      2'd2:    return a >> s;
      2'd3:    return $unsigned($signed(a) >>> s);
      default: return a << s;
    endcase
`endif
  endfunction

  // Advance one cycle: sample outputs at the falling edge, log accepted requests, step past the rising edge.
  task automatic cycle(output logic ov, output logic ir, output logic [DW-1:0] res,
                       output logic [TW-1:0] tg);
    item_t it;
    @(negedge clk);
    ov  = out_valid;
    ir  = in_ready;
    res = out_result;
    tg  = out_tag;
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      it.data = model(in_a, in_shamt, in_op);
      it.tag  = in_tag;
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic [TW-1:0] tag);
    in_valid = 1'b1;
    case ($urandom_range(0, 3))
      0:       in_a = 32'h8000_0000 | DW'($urandom);
      1:       in_a = DW'($urandom_range(0, 255));
      default: in_a = DW'($urandom);
    endcase
    in_shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    in_op    = 3'($urandom_range(0, 7));
    in_tag   = tag;
  endtask

  task automatic test_reset();
    logic ov, ir;
    logic [DW-1:0] res;
    logic [TW-1:0] tg;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle(ov, ir, res, tg);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov); end
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", ir); end
    checks++; if (res !== '0) begin errors++; $display("FAIL reset_out_result got %h want 0", res); end
    checks++; if (tg !== '0) begin errors++; $display("FAIL reset_out_tag got %h want 0", tg); end
    rst = 1'b0;
    cycle(ov, ir, res, tg);
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", ir); end
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [DW-1:0] ta [10];
    logic [4:0]    ts [10];
    logic [2:0]    to [10];
    logic [DW-1:0] te [10];
    logic ov, ir;
    logic [DW-1:0] res;
    logic [TW-1:0] tg;
    int lat;
    ta[0] = 32'h0000_0001; ts[0] = 5'd31; to[0] = 3'b000; te[0] = 32'h8000_0000;
    ta[1] = 32'h8000_00F0; ts[1] = 5'd4;  to[1] = 3'b010; te[1] = 32'h0800_000F;
    ta[2] = 32'h8000_00F0; ts[2] = 5'd4;  to[2] = 3'b011; te[2] = 32'hF800_000F;
    ta[3] = 32'h8000_00F0; ts[3] = 5'd0;  to[3] = 3'b010; te[3] = 32'h8000_00F0;
    ta[4] = 32'h8000_00F0; ts[4] = 5'd0;  to[4] = 3'b011; te[4] = 32'h8000_00F0;
    ta[5] = 32'h1234_5678; ts[5] = 5'd0;  to[5] = 3'b001; te[5] = 32'h1234_5678;
`ifdef SHIFTER_ROTATE_EN
    ta[6] = 32'h0000_00F1; ts[6] = 5'd4;  to[6] = 3'b101; te[6] = 32'h1000_000F;
    ta[7] = 32'h8000_0001; ts[7] = 5'd1;  to[7] = 3'b100; te[7] = 32'h0000_0003;
    ta[8] = 32'h0000_00F1; ts[8] = 5'd4;  to[8] = 3'b110; te[8] = 32'h0000_00F1;
    ta[9] = 32'h8000_00F0; ts[9] = 5'd4;  to[9] = 3'b111; te[9] = 32'h8000_00F0;
`else
    ta[6] = 32'h0000_00F1; ts[6] = 5'd4;  to[6] = 3'b101; te[6] = 32'h0000_0F10;
    ta[7] = 32'h8000_0001; ts[7] = 5'd1;  to[7] = 3'b100; te[7] = 32'h0000_0002;
    ta[8] = 32'h0000_00F1; ts[8] = 5'd4;  to[8] = 3'b110; te[8] = 32'h0000_000F;
    ta[9] = 32'h8000_00F0; ts[9] = 5'd4;  to[9] = 3'b111; te[9] = 32'hF800_000F;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_shamt = ts[i]; in_op = to[i]; in_tag = TW'(i);
      cycle(ov, ir, res, tg);
      in_valid = 1'b0;
      checks++;
      if (ir !== 1'b1) begin errors++; $display("FAIL dir%0d_accept in_ready %b want 1", i, ir); end
      lat = 0;
      ov  = 1'b0;
      while (ov !== 1'b1 && lat < 10) begin
        cycle(ov, ir, res, tg);
        lat++;
      end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      checks++;
      if (res !== te[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, te[i]); end
      checks++;
      if (tg !== TW'(i)) begin errors++; $display("FAIL dir%0d_tag got %h want %h", i, tg, TW'(i)); end
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic ov, ir;
    logic [DW-1:0] res;
    logic [TW-1:0] tg;
    item_t it;
    int sent, got, cyc, last_cyc;
    sent = 0; got = 0; cyc = 0; last_cyc = 0;
    out_ready = 1'b1;
    while (got < 8 && cyc < 30) begin
      if (sent < 8) drive_rand(TW'(sent)); else in_valid = 1'b0;
      cycle(ov, ir, res, tg);
      if (in_valid && ir) sent++;
      if (ov === 1'b1) begin
        checks++;
        if (got > 0 && last_cyc != cyc - 1) begin
          errors++; $display("FAIL stream_gap result %0d at cycle %0d previous %0d", got, cyc, last_cyc);
        end
        checks++;
        if (tg !== TW'(got)) begin errors++; $display("FAIL stream_tag got %h want %h", tg, TW'(got)); end
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_unexpected result %h", res);
        end else begin
          it = exp_q.pop_front();
          checks++;
          if (res !== it.data) begin errors++; $display("FAIL stream_result got %h want %h", res, it.data); end
        end
        last_cyc = cyc;
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8) begin errors++; $display("FAIL stream_count got %0d want 8", got); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic ov, ir;
    logic [DW-1:0] res, res0;
    logic [TW-1:0] tg, tg0;
    item_t it;
    int n, delivered, accepted;
    out_ready = 1'b0;
    ov = 1'b0; n = 0;
    while (ov !== 1'b1 && n < 10) begin
      drive_rand(TW'(n + 3));
      cycle(ov, ir, res, tg);
      n++;
    end
    checks++;
    if (ov !== 1'b1) begin errors++; $display("FAIL bp_fill out_valid never rose"); end
    accepted = exp_q.size();
    checks++;
    if (accepted != LAT) begin errors++; $display("FAIL bp_fill_count got %0d want %0d", accepted, LAT); end
    res0 = res; tg0 = tg;
    for (int i = 0; i < 5; i++) begin
      drive_rand(TW'(i));
      cycle(ov, ir, res, tg);
      checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", ir); end
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", ov); end
      checks++; if (res !== res0) begin errors++; $display("FAIL bp_result_stable got %h want %h", res, res0); end
      checks++; if (tg !== tg0) begin errors++; $display("FAIL bp_tag_stable got %h want %h", tg, tg0); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    delivered = 0; n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle(ov, ir, res, tg);
      if (ov === 1'b1) begin
        it = exp_q.pop_front();
        checks++;
        if (res !== it.data || tg !== it.tag) begin
          errors++; $display("FAIL bp_drain got %h/%h want %h/%h", res, tg, it.data, it.tag);
        end
        delivered++;
      end
      n++;
    end
    cycle(ov, ir, res, tg);
    checks++;
    if (delivered != accepted || ov !== 1'b0) begin
      errors++; $display("FAIL bp_delivered got %0d (extra valid %b) want %0d", delivered, ov, accepted);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic ov, ir;
    logic [DW-1:0] res;
    logic [TW-1:0] tg;
    item_t it;
    int n;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_rand(TW'($urandom)); else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(ov, ir, res, tg);
      checks++;
      if (ir !== (!ov || out_ready)) begin
        errors++; $display("FAIL rand_in_ready got %b out_valid %b out_ready %b", ir, ov, out_ready);
      end
      if (ov === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected result %h tag %h", res, tg);
        end else begin
          it = exp_q.pop_front();
          checks++;
          if (res !== it.data || tg !== it.tag) begin
            errors++; $display("FAIL rand_result got %h/%h want %h/%h", res, tg, it.data, it.tag);
          end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle(ov, ir, res, tg);
      if (ov === 1'b1) begin
        it = exp_q.pop_front();
        checks++;
        if (res !== it.data || tg !== it.tag) begin
          errors++; $display("FAIL rand_drain got %h/%h want %h/%h", res, tg, it.data, it.tag);
        end
      end
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic ov, ir;
    logic [DW-1:0] res;
    logic [TW-1:0] tg;
    item_t it;
    int lat;
    out_ready = 1'b1;
    drive_rand(4'hA);
    cycle(ov, ir, res, tg);
    drive_rand(4'hB);
    cycle(ov, ir, res, tg);
    in_valid = 1'b0;
    rst = 1'b1;
    drive_rand(4'hC);
    cycle(ov, ir, res, tg);
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", ir); end
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    cycle(ov, ir, res, tg);
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b want 1", ir); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mid_release_out_valid got %b want 0", ov); end
    for (int i = 0; i < 5; i++) begin
      cycle(ov, ir, res, tg);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL mid_ghost_output got %h/%h", res, tg); end
    end
    drive_rand(4'h5);
    cycle(ov, ir, res, tg);
    in_valid = 1'b0;
    lat = 0; ov = 1'b0;
    while (ov !== 1'b1 && lat < 10) begin
      cycle(ov, ir, res, tg);
      lat++;
    end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL mid_new_latency got %0d want %0d", lat, LAT); end
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL mid_new_not_accepted");
    end else begin
      it = exp_q.pop_front();
      checks++;
      if (res !== it.data || tg !== it.tag) begin
        errors++; $display("FAIL mid_new_result got %h/%h want %h/%h", res, tg, it.data, it.tag);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
